// File: rtl/instruction_fetch.sv
// Instruction fetch unit: FSM-driven memory requests feeding a small PC-tagged instruction FIFO.
// Optional misaligned-redirect fault detection is enabled by defining IFETCH_MISALIGN_CHECK_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        instr_misaligned_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, STALL, HALT} state_t;

    state_t          state, state_next;
    logic [31:0]     fetch_pc;
    logic [31:0]     data_mem [FIFO_DEPTH];
    logic [31:0]     pc_mem   [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_next;
    logic            push, pop;
    logic            misalign_redirect;
    logic [31:0]     redirect_target;
    logic            misaligned;
    logic [31:0]     fault_pc;

    assign mem_req_o     = (state == FETCH);
    assign mem_addr_o    = fetch_pc;
    assign instr_valid_o = (count != '0);

    // A redirect beats both an arriving ack and a consumer pop.
    assign push = mem_req_o && mem_ack_i && !redirect_i;
    assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

    assign count_next = redirect_i ? '0 : (count + CW'(push) - CW'(pop));

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign misalign_redirect = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign redirect_target   = redirect_pc_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned <= 1'b0;
            fault_pc   <= '0;
        end else if (redirect_i) begin
            misaligned <= misalign_redirect;
            fault_pc   <= redirect_pc_i;
        end
    end
`else
    assign misalign_redirect = 1'b0;
    assign redirect_target   = redirect_pc_i & 32'hFFFF_FFFC;
    assign misaligned        = 1'b0;
    assign fault_pc          = '0;
`endif

    assign instr_misaligned_o = misaligned;
    assign instr_o    = instr_valid_o ? data_mem[rd_ptr] : '0;
    assign instr_pc_o = instr_valid_o ? pc_mem[rd_ptr] : (misaligned ? fault_pc : '0);

    // Stall decisions look at the post-update occupancy so a pop re-opens fetch next cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (count_next == FULL) state_next = STALL;
            STALL:   if (count_next < FULL)  state_next = FETCH;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
        if (redirect_i)
            state_next = misalign_redirect ? HALT : FETCH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_VECTOR;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (redirect_i) begin
                fetch_pc <= redirect_target;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (push) begin
                    data_mem[wr_ptr] <= mem_data_i;
                    pc_mem[wr_ptr]   <= fetch_pc;
                    wr_ptr           <= wr_ptr + 1'b1;
                    fetch_pc         <= fetch_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule
